pipelined_addsub: RTL

//   Parametrised WIDTH-bit adder/subtractor for the combinational arithmetic library.
//   - Operands are split into CHUNK-bit slices; carry ripples one slice per stage.
//   - Throughput is one operation per clock; valid/ready handshake on input and output.
//   - Reports unsigned carry/borrow and signed overflow alongside the sum.

---
 rtl/pipelined_addsub.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor split into CHUNK-bit slices.
// The carry ripples one slice per pipeline stage, so a result appears
// STAGES = WIDTH/CHUNK cycles after acceptance. One global enable stalls
// every stage together. The output carries the unsigned carry/borrow flag
// and the signed overflow flag.
module pipelined_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;
   localparam int MSB    = WIDTH - 1;

   // Reject geometries where the slices do not tile the operand exactly.
   if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   // Stage registers; index k holds what stage k produced at the last advance.
   logic [STAGES-1:0][WIDTH-1:0] a_q;   // operand A, delayed alongside
   logic [STAGES-1:0][WIDTH-1:0] b_q;   // effective operand B (already inverted for sub)
   logic [STAGES-1:0][WIDTH-1:0] s_q;   // partial sum, slices 0..k valid
   logic [STAGES-1:0]            c_q;   // carry out of slice k
   logic [STAGES-1:0]            v_q;   // stage valid
   logic                         ov_q;  // signed overflow of the final stage

   // Stage inputs and next-state values.
   logic [STAGES-1:0][WIDTH-1:0] a_in;
   logic [STAGES-1:0][WIDTH-1:0] b_in;
   logic [STAGES-1:0][WIDTH-1:0] s_in;
   logic [STAGES-1:0][WIDTH-1:0] s_nx;
   logic [STAGES-1:0]            c_in;
   logic [STAGES-1:0]            c_nx;
   logic [STAGES-1:0]            v_in;
   logic [STAGES-1:0][CHUNK:0]   slice_sum;
   logic                         ov_nx;
   logic                         advance;

   // The whole pipe moves only when the output slot is empty or being drained.
   assign advance  = !v_q[LAST] || out_ready;
   assign in_ready = advance;

   // Stage 0 takes the ports; every later stage takes its predecessor's registers.
   // NOTE: every variable written here is assigned on every pass, so the block
   // stays purely combinational and no latch is inferred.
   always_comb begin
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in[0] = sub;             // +1 of the two's-complement negate
      v_in[0] = in_valid;
      s_in[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
         v_in[k] = v_q[k-1];
         s_in[k] = s_q[k-1];
      end
   end

   // Each stage adds its own slice plus the incoming carry and patches that
   // slice into the partial sum it passes on.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         slice_sum[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, c_in[k]};
         c_nx[k]      = slice_sum[k][CHUNK];
         s_nx[k]      = s_in[k];
         s_nx[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
      end
   end

   // Signed overflow: operands agree in sign but the result does not.
   assign ov_nx = (a_in[LAST][MSB] == b_in[LAST][MSB]) && (s_nx[LAST][MSB] != a_in[LAST][MSB]);

   // Pipeline registers: cleared by reset, otherwise advance together or hold together.
   // NOTE: non-blocking assignments make every stage sample its predecessor's
   // pre-edge value, which is what keeps the stages independent.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         s_q  <= '0;
         c_q  <= '0;
         v_q  <= '0;
         ov_q <= 1'b0;
      end else if (advance) begin
         a_q  <= a_in;
         b_q  <= b_in;
         s_q  <= s_nx;
         c_q  <= c_nx;
         v_q  <= v_in;
         ov_q <= ov_nx;
      end
   end

   // Operand slices already consumed are carried only for structural
   // regularity; synthesis trims them. Gathered here so they have a reader.
   logic unused_operand_bits;
   assign unused_operand_bits = ^{a_q, b_q};

   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign carry_out = c_q[LAST];
   assign overflow  = ov_q;

endmodule
